// File: rtl/multicycle_ctrl_if.sv
// Purpose : controller <-> datapath bundle for the 16-bit multicycle CPU.
// Latency : n/a (wires only).
// Backpressure: none; the datapath samples the controls every cycle.
// Ports   : op/funct/zero flow datapath->controller; everything else is a
//           control output from the controller.
interface multicycle_ctrl_if;
  logic [3:0] op;
  logic [2:0] funct;
  logic       zero;
  logic [2:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       i_or_d;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       pc_en;
  logic       instr_done;
  logic       illegal;

  // Controller side.
  modport master (
    input  op, funct, zero,
    output alu_control, alu_src_a, alu_src_b, pc_src, i_or_d, mem_write,
           ir_write, reg_write, reg_dst, mem_to_reg, pc_en, instr_done, illegal
  );

  // Datapath side.
  modport slave (
    output op, funct, zero,
    input  alu_control, alu_src_a, alu_src_b, pc_src, i_or_d, mem_write,
           ir_write, reg_write, reg_dst, mem_to_reg, pc_en, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Purpose : main control FSM + ALU decoder for the 16-bit multicycle datapath.
// Latency : Moore outputs decoded combinationally from state; 3-5 states per
//           instruction plus MEM_LAT-1 extra cycles in FETCH and in MEMRD.
// Backpressure: none; memory latency is the fixed parameter MEM_LAT (1-15).
// Ports   : clk, reset (sync, active-high); bus = multicycle_ctrl_if.master.
// Option  : define CTRL_BNE_EN to decode opcode 0110 as BNE (else illegal).
module multicycle_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b0001;
  localparam logic [3:0] OP_SW   = 4'b0010;
  localparam logic [3:0] OP_BEQ  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_J    = 4'b0101;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;

  logic       wait_done;
  logic       pc_write;
  logic       branch_cond;
  logic       take_branch;
  logic       op_is_bne;
  logic [2:0] funct_ctl;
  logic       funct_bad;

`ifdef CTRL_BNE_EN
  assign op_is_bne = (bus.op == 4'b0110);
`else
  assign op_is_bne = 1'b0;
`endif

  // R-type funct -> ALU F. Unknown functs drive 011 and flag illegal.
  always_comb begin
    funct_bad = 1'b0;
    case (bus.funct)
      3'b000:  funct_ctl = 3'b010;
      3'b001:  funct_ctl = 3'b110;
      3'b010:  funct_ctl = 3'b000;
      3'b011:  funct_ctl = 3'b001;
      3'b100:  funct_ctl = 3'b111;
      default: begin
        funct_ctl = 3'b011;
        funct_bad = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign wait_done   = (cnt_q == LAST_CNT);
  assign bus.illegal = illegal_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = 4'd0;
    illegal_d       = illegal_q;
    pc_write        = 1'b0;
    branch_cond     = 1'b0;
    bus.alu_control = 3'b000;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.pc_src      = 2'b00;
    bus.i_or_d      = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.reg_write   = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.instr_done  = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.alu_src_b   = 2'b01;
        bus.alu_control = 3'b010;
        // Memory wait: hold until the last cycle, then load IR and bump PC.
        if (wait_done) begin
          bus.ir_write = 1'b1;
          pc_write     = 1'b1;
          state_d      = S_DECODE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DECODE: begin
        bus.alu_src_b   = 2'b11;
        bus.alu_control = 3'b010;
        case (bus.op)
          OP_R:         state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            if (op_is_bne) begin
              state_d = S_BRANCH;
            end else begin
              state_d        = S_FETCH;
              illegal_d      = 1'b1;
              bus.instr_done = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_src_b   = 2'b10;
        bus.alu_control = 3'b010;
        if (state_q == S_ADDIEX) state_d = S_ADDIWB;
        else                     state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.i_or_d = 1'b1;
        if (wait_done) state_d = S_MEMWB;
        else           cnt_d   = cnt_q + 4'd1;
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWR: begin
        bus.i_or_d     = 1'b1;
        bus.mem_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_EXEC: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_control = funct_ctl;
        if (funct_bad) illegal_d = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_ADDIWB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_control = 3'b110;
        bus.pc_src      = 2'b01;
        branch_cond     = 1'b1;
        bus.instr_done  = 1'b1;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_src     = 2'b10;
        pc_write       = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    take_branch = op_is_bne ? ~bus.zero : bus.zero;
    bus.pc_en   = pc_write | (branch_cond & take_branch);

    // Reset aborts whatever is in flight: no strobes, muxes parked on FETCH.
    if (reset) begin
      bus.alu_control = 3'b010;
      bus.alu_src_a   = 1'b0;
      bus.alu_src_b   = 2'b01;
      bus.pc_src      = 2'b00;
      bus.i_or_d      = 1'b0;
      bus.reg_dst     = 1'b0;
      bus.mem_to_reg  = 1'b0;
      bus.mem_write   = 1'b0;
      bus.ir_write    = 1'b0;
      bus.reg_write   = 1'b0;
      bus.pc_en       = 1'b0;
      bus.instr_done  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose : self-checking bench for multicycle_ctrl (MEM_LAT=1 and MEM_LAT=3).
// Latency : every cycle's control word is compared to a phase-list model.
// Backpressure: none.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       pc_en;
    logic       instr_done;
    logic       illegal;
  } out_t;

  // Instruction phases as seen by the datapath, one entry per clock.
  localparam int P_FWAIT = 0, P_FLAST = 1, P_DEC = 2, P_DECILL = 3, P_MEMADR = 4,
                 P_MEMRD = 5, P_MEMWB = 6, P_MEMWR = 7, P_EXEC = 8, P_ALUWB = 9,
                 P_ADDIEX = 10, P_ADDIWB = 11, P_BRANCH = 12, P_JUMP = 13;

  logic       clk = 1'b0;
  logic       reset_r;
  logic [3:0] op_r;
  logic [2:0] funct_r;
  logic       zero_r;
  logic       sel;
  out_t       obs1, obs3, obs;
  int         chk_total = 0;
  int         chk_pass  = 0;
  logic       ill_m;
  int         seq[$];

  always #5 clk = ~clk;

  multicycle_ctrl_if if1();
  multicycle_ctrl_if if3();

  assign if1.op = op_r;  assign if1.funct = funct_r;  assign if1.zero = zero_r;
  assign if3.op = op_r;  assign if3.funct = funct_r;  assign if3.zero = zero_r;

  multicycle_ctrl #(.MEM_LAT(1)) u_dut1 (.clk(clk), .reset(reset_r), .bus(if1));
  multicycle_ctrl #(.MEM_LAT(3)) u_dut3 (.clk(clk), .reset(reset_r), .bus(if3));

  assign obs1 = {if1.alu_control, if1.alu_src_a, if1.alu_src_b, if1.pc_src, if1.i_or_d,
                 if1.mem_write, if1.ir_write, if1.reg_write, if1.reg_dst, if1.mem_to_reg,
                 if1.pc_en, if1.instr_done, if1.illegal};
  assign obs3 = {if3.alu_control, if3.alu_src_a, if3.alu_src_b, if3.pc_src, if3.i_or_d,
                 if3.mem_write, if3.ir_write, if3.reg_write, if3.reg_dst, if3.mem_to_reg,
                 if3.pc_en, if3.instr_done, if3.illegal};
  assign obs  = sel ? obs3 : obs1;

  function automatic int lat_of();
    return sel ? 3 : 1;
  endfunction

  function automatic bit bne_legal();
`ifdef CTRL_BNE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Expand one instruction into its phase list.
  function automatic void build_seq(input logic [3:0] op, input int lat);
    seq.delete();
    for (int i = 0; i < lat - 1; i++) seq.push_back(P_FWAIT);
    seq.push_back(P_FLAST);
    case (op)
      4'd0: begin seq.push_back(P_DEC); seq.push_back(P_EXEC); seq.push_back(P_ALUWB); end
      4'd1: begin
        seq.push_back(P_DEC); seq.push_back(P_MEMADR);
        for (int i = 0; i < lat; i++) seq.push_back(P_MEMRD);
        seq.push_back(P_MEMWB);
      end
      4'd2: begin seq.push_back(P_DEC); seq.push_back(P_MEMADR); seq.push_back(P_MEMWR); end
      4'd3: begin seq.push_back(P_DEC); seq.push_back(P_BRANCH); end
      4'd4: begin seq.push_back(P_DEC); seq.push_back(P_ADDIEX); seq.push_back(P_ADDIWB); end
      4'd5: begin seq.push_back(P_DEC); seq.push_back(P_JUMP); end
      4'd6: begin
        if (bne_legal()) begin seq.push_back(P_DEC); seq.push_back(P_BRANCH); end
        else seq.push_back(P_DECILL);
      end
      default: seq.push_back(P_DECILL);
    endcase
  endfunction

  function automatic logic [2:0] funct_f(input logic [2:0] f);
    logic [2:0] tbl [0:4] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    return (f <= 3'd4) ? tbl[f] : 3'b011;
  endfunction

  function automatic out_t expect_out(input int ph, input logic [3:0] op,
                                      input logic [2:0] f, input logic z, input logic ill);
    out_t e = '0;
    e.illegal = ill;
    case (ph)
      P_FWAIT, P_FLAST: begin
        e.alu_src_b = 2'b01; e.alu_control = 3'b010;
        if (ph == P_FLAST) begin e.ir_write = 1'b1; e.pc_en = 1'b1; end
      end
      P_DEC, P_DECILL: begin
        e.alu_src_b = 2'b11; e.alu_control = 3'b010; e.instr_done = (ph == P_DECILL);
      end
      P_MEMADR, P_ADDIEX: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_control = 3'b010; end
      P_MEMRD:  e.i_or_d = 1'b1;
      P_MEMWR:  begin e.i_or_d = 1'b1; e.mem_write = 1'b1; e.instr_done = 1'b1; end
      P_MEMWB:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1; end
      P_EXEC:   begin e.alu_src_a = 1'b1; e.alu_control = funct_f(f); end
      P_ALUWB:  begin e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_done = 1'b1; end
      P_ADDIWB: begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
      P_BRANCH: begin
        e.alu_src_a = 1'b1; e.alu_control = 3'b110; e.pc_src = 2'b01; e.instr_done = 1'b1;
        e.pc_en = (op == 4'd6) ? ~z : z;
      end
      P_JUMP:   begin e.pc_src = 2'b10; e.pc_en = 1'b1; e.instr_done = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  // Values while reset is held: FETCH muxes, no strobes.
  function automatic out_t reset_out(input logic ill);
    out_t e = '0;
    e.alu_src_b = 2'b01; e.alu_control = 3'b010; e.illegal = ill;
    return e;
  endfunction

  function automatic logic ill_after(input int ph, input logic [2:0] f, input logic ill);
    return ill | (ph == P_DECILL) | ((ph == P_EXEC) && (f > 3'd4));
  endfunction

  task automatic apply_reset();
    reset_r = 1'b1;
    @(posedge clk); #1;
    reset_r = 1'b0;
    ill_m   = 1'b0;
  endtask

  task automatic test_reset();
    reset_r = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk_total++;
      if (obs !== reset_out(1'b0))
        $display("FAIL reset cyc%0d got=%h exp=%h", c, obs, reset_out(1'b0));
      else chk_pass++;
      @(posedge clk); #1;
    end
    reset_r = 1'b0;
    ill_m   = 1'b0;
  endtask

  task automatic test_rtype();
    op_r = 4'd0; funct_r = 3'b001; zero_r = 1'b0;
    build_seq(op_r, lat_of());
    foreach (seq[i]) begin
      out_t e;
      @(negedge clk);
      e = expect_out(seq[i], op_r, funct_r, zero_r, ill_m);
      chk_total++;
      if (obs !== e) $display("FAIL rtype cyc%0d ph%0d got=%h exp=%h", i, seq[i], obs, e);
      else chk_pass++;
      ill_m = ill_after(seq[i], funct_r, ill_m);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    for (int z = 1; z >= 0; z--) begin
      op_r = 4'd3; funct_r = 3'($urandom_range(0, 7)); zero_r = z[0];
      build_seq(op_r, lat_of());
      seq.push_back(P_FWAIT + (lat_of() == 1 ? 1 : 0)); // FETCH must follow
      foreach (seq[i]) begin
        out_t e;
        @(negedge clk);
        e = expect_out(seq[i], op_r, funct_r, zero_r, ill_m);
        chk_total++;
        if (obs !== e) $display("FAIL beq_z%0d cyc%0d got=%h exp=%h", z, i, obs, e);
        else chk_pass++;
        @(posedge clk); #1;
      end
      apply_reset();
    end
  endtask

  task automatic test_illegal();
    logic [3:0] ops [0:2] = '{4'hF, 4'd4, 4'd5};
    for (int k = 0; k < 3; k++) begin
      op_r = ops[k]; funct_r = 3'd0; zero_r = 1'b0;
      build_seq(op_r, lat_of());
      foreach (seq[i]) begin
        out_t e;
        @(negedge clk);
        e = expect_out(seq[i], op_r, funct_r, zero_r, ill_m);
        chk_total++;
        if (obs !== e) $display("FAIL illegal k%0d cyc%0d got=%h exp=%h", k, i, obs, e);
        else chk_pass++;
        ill_m = ill_after(seq[i], funct_r, ill_m);
        @(posedge clk); #1;
      end
    end
    apply_reset();
    @(negedge clk);
    chk_total++;
    if (obs.illegal !== 1'b0) $display("FAIL illegal_clear got=%b exp=0", obs.illegal);
    else chk_pass++;
    @(posedge clk); #1;
    apply_reset();
  endtask

  task automatic test_reset_mid();
    op_r = 4'd2; funct_r = 3'd0; zero_r = 1'b0;
    build_seq(op_r, lat_of());
    for (int i = 0; i < seq.size(); i++) begin
      out_t e;
      if (i == seq.size() - 1) reset_r = 1'b1;  // lands on MEMWR
      @(negedge clk);
      e = reset_r ? reset_out(ill_m) : expect_out(seq[i], op_r, funct_r, zero_r, ill_m);
      chk_total++;
      if (obs !== e) $display("FAIL reset_mid cyc%0d got=%h exp=%h", i, obs, e);
      else chk_pass++;
      @(posedge clk); #1;
    end
    reset_r = 1'b0;
    ill_m   = 1'b0;
    // Next instruction must start with a clean FETCH.
    op_r = 4'd4;
    build_seq(op_r, lat_of());
    foreach (seq[i]) begin
      out_t e;
      @(negedge clk);
      e = expect_out(seq[i], op_r, funct_r, zero_r, ill_m);
      chk_total++;
      if (obs !== e) $display("FAIL after_reset cyc%0d got=%h exp=%h", i, obs, e);
      else chk_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bne();
    for (int z = 0; z < 2; z++) begin
      op_r = 4'd6; funct_r = 3'd0; zero_r = z[0];
      build_seq(op_r, lat_of());
      foreach (seq[i]) begin
        out_t e;
        @(negedge clk);
        e = expect_out(seq[i], op_r, funct_r, zero_r, ill_m);
        chk_total++;
        if (obs !== e) $display("FAIL bne_z%0d cyc%0d got=%h exp=%h", z, i, obs, e);
        else chk_pass++;
        ill_m = ill_after(seq[i], funct_r, ill_m);
        @(posedge clk); #1;
      end
    end
    apply_reset();
  endtask

  task automatic test_lw_lat3();
    sel = 1'b1;
    apply_reset();
    op_r = 4'd1; funct_r = 3'd0; zero_r = 1'b1;
    build_seq(op_r, lat_of());
    foreach (seq[i]) begin
      out_t e;
      @(negedge clk);
      e = expect_out(seq[i], op_r, funct_r, zero_r, ill_m);
      chk_total++;
      if (obs !== e) $display("FAIL lw_lat3 cyc%0d ph%0d got=%h exp=%h", i, seq[i], obs, e);
      else chk_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      apply_reset();
      for (int n = 0; n < 40; n++) begin
        int pick = $urandom_range(0, 9);
        op_r    = (pick <= 6) ? 4'(pick) : 4'($urandom_range(7, 15));
        funct_r = 3'($urandom_range(0, 7));
        zero_r  = 1'($urandom_range(0, 1));
        build_seq(op_r, lat_of());
        foreach (seq[i]) begin
          out_t e;
          @(negedge clk);
          e = expect_out(seq[i], op_r, funct_r, zero_r, ill_m);
          chk_total++;
          if (obs !== e)
            $display("FAIL random lat%0d n%0d op%h cyc%0d got=%h exp=%h",
                     lat_of(), n, op_r, i, obs, e);
          else chk_pass++;
          ill_m = ill_after(seq[i], funct_r, ill_m);
          @(posedge clk); #1;
        end
      end
    end
  endtask

  initial begin
    reset_r = 1'b1; op_r = 4'd0; funct_r = 3'd0; zero_r = 1'b0; sel = 1'b0; ill_m = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_bne();
    test_lw_lat3();
    test_random();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
